// File: rtl/grid_deposit_ctrl_pkg.sv
// Shared definitions for the charge-grid deposit path: grid address type,
// grid word width, grid_mem read latency and the deposit request bundle.
package grid_deposit_ctrl_pkg;

    localparam int unsigned PINT        = 6;   // bits per grid coordinate
    localparam int unsigned CWIDTH      = 24;  // charge word width
    localparam int unsigned GRID_RD_LAT = 4;   // grid_mem addra -> douta latency

    typedef struct packed {
        logic [PINT-1:0] y;
        logic [PINT-1:0] x;
    } addr_t;

    typedef struct packed {
        addr_t [3:0]                 addr;
        logic  [3:0][CWIDTH-1:0]     inc;
        logic  [3:0]                 mask;
    } deposit_req_t;

    // grid_mem bank of a grid point: one bank per {y,x} parity pair
    function automatic logic [1:0] bank_sel(input addr_t a);
        return {a.y[0], a.x[0]};
    endfunction

    // True when two participating lanes target the same bank
    function automatic logic bank_conflict(input addr_t [3:0] addr, input logic [3:0] mask);
        logic conflict;
        conflict = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (mask[i] && mask[j] && (bank_sel(addr[i]) == bank_sel(addr[j]))) begin
                    conflict = 1'b1;
                end
            end
        end
        return conflict;
    endfunction

endpackage

// File: rtl/grid_hazard_cam.sv
// In-flight address tracker for the deposit scheduler. Shifts one address set
// per cycle alongside the top-level pipe and flags any overlap between the
// incoming request and a set that has not yet safely committed to the grid.
module grid_hazard_cam
    import grid_deposit_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = GRID_RD_LAT + 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  addr_t [3:0] push_addr,
    input  logic  [3:0] push_mask,
    input  addr_t [3:0] req_addr,
    input  logic  [3:0] req_mask,
    output logic        match
);

    addr_t [3:0] addr_q [DEPTH];
    logic  [3:0] mask_q [DEPTH];

    // Lane masks: a cleared mask marks an empty slot, so only masks need reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                mask_q[s] <= '0;
            end
        end else begin
            mask_q[0] <= push ? push_mask : 4'b0000;
            for (int s = 1; s < DEPTH; s++) begin
                mask_q[s] <= mask_q[s-1];
            end
        end
    end

    // Address sets shift in lockstep with the masks
    always_ff @(posedge clk) begin
        addr_q[0] <= push_addr;
        for (int s = 1; s < DEPTH; s++) begin
            addr_q[s] <= addr_q[s-1];
        end
    end

    // Any participating incoming lane equal to any participating stored lane
    always_comb begin
        match = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (mask_q[s][i] && req_mask[j] && (addr_q[s][i] == req_addr[j])) begin
                        match = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/grid_deposit_ctrl.sv
// Read-modify-write scheduler for the charge grid_mem: reads four points on
// port A, adds signed increments with saturation and writes back on port B.
// One request per cycle; stalls only on read-after-write overlap.
module grid_deposit_ctrl
    import grid_deposit_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = CWIDTH,
    parameter int unsigned RD_LAT = GRID_RD_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  addr_t [3:0]           req_addr,
    input  logic  [3:0][WIDTH-1:0] req_inc,
    input  logic  [3:0]           req_mask,
    output logic  [3:0]           mem_wea,
    output addr_t [3:0]           mem_addra,
    output logic  [3:0][WIDTH-1:0] mem_dina,
    output logic  [3:0]           mem_web,
    output addr_t [3:0]           mem_addrb,
    output logic  [3:0][WIDTH-1:0] mem_dinb,
    output logic                  mem_swap_rout,
    input  logic  [3:0][WIDTH-1:0] mem_douta,
    output logic                  idle,
    output logic                  sat_flag,
    output logic                  err_flag
);

    // Stage RD_LAT lines up with mem_douta for its entry
    localparam int unsigned NSTG = RD_LAT + 1;

    logic                   ready_q;
    logic                   hazard;
    logic                   dup;
    logic                   accept;
    logic                   push;
    logic [NSTG-1:0]        pv_q;
    addr_t [3:0]            pa_q [NSTG];
    logic  [3:0][WIDTH-1:0] pi_q [NSTG];
    logic  [3:0]            pm_q [NSTG];
    logic                   wr_valid_q;
    logic                   guard_valid_q;
    logic  [3:0][WIDTH:0]   wide;
    logic  [3:0][WIDTH-1:0] sum;
    logic  [3:0]            clamp;

    assign mem_wea       = '0;
    assign mem_dina      = '0;
    assign mem_swap_rout = 1'b1;

    assign dup       = bank_conflict(req_addr, req_mask);
    assign req_ready = ready_q & (~hazard | ~req_valid);
    assign accept    = req_valid & req_ready;
    assign push      = accept & ~dup;
    assign idle      = ~(|pv_q) & ~wr_valid_q & ~guard_valid_q;

    // Tracks pipe stages 0..RD_LAT, the write register and the post-write guard
    // slot, so a conflicting read waits until grid_mem has committed the write.
    grid_hazard_cam #(
        .DEPTH (RD_LAT + 3)
    ) u_cam (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (req_addr),
        .push_mask (req_mask),
        .req_addr  (req_addr),
        .req_mask  (req_mask),
        .match     (hazard)
    );

    // Saturating add of read data and increment, per lane
    always_comb begin
        wide  = '0;
        sum   = '0;
        clamp = '0;
        for (int l = 0; l < 4; l++) begin
            wide[l] = {mem_douta[l][WIDTH-1], mem_douta[l]}
                    + {pi_q[RD_LAT][l][WIDTH-1], pi_q[RD_LAT][l]};
            if (wide[l][WIDTH] != wide[l][WIDTH-1]) begin
                sum[l]   = wide[l][WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
                clamp[l] = pm_q[RD_LAT][l];
            end else begin
                sum[l] = wide[l][WIDTH-1:0];
            end
        end
    end

    // Control: ready, read address, valid chain, sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q       <= 1'b0;
            mem_addra     <= '0;
            pv_q          <= '0;
            wr_valid_q    <= 1'b0;
            guard_valid_q <= 1'b0;
            sat_flag      <= 1'b0;
            err_flag      <= 1'b0;
        end else begin
            ready_q       <= 1'b1;
            if (push) begin
                mem_addra <= req_addr;
            end
            pv_q          <= {pv_q[NSTG-2:0], push};
            wr_valid_q    <= pv_q[RD_LAT];
            guard_valid_q <= wr_valid_q;
            if (pv_q[RD_LAT] && (|clamp)) begin
                sat_flag <= 1'b1;
            end
            if (accept && dup) begin
                err_flag <= 1'b1;
            end
        end
    end

    // Entry payload shift pipe; validity lives in pv_q
    always_ff @(posedge clk) begin
        pa_q[0] <= req_addr;
        pi_q[0] <= req_inc;
        pm_q[0] <= req_mask;
        for (int s = 1; s < NSTG; s++) begin
            pa_q[s] <= pa_q[s-1];
            pi_q[s] <= pi_q[s-1];
            pm_q[s] <= pm_q[s-1];
        end
    end

    // Port B write register
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_web   <= '0;
            mem_addrb <= '0;
            mem_dinb  <= '0;
        end else begin
            mem_web <= pv_q[RD_LAT] ? pm_q[RD_LAT] : 4'b0000;
            if (pv_q[RD_LAT]) begin
                mem_addrb <= pa_q[RD_LAT];
                mem_dinb  <= sum;
            end
        end
    end

endmodule

// File: tb/tb_grid_deposit_ctrl.sv
// Bench for grid_deposit_ctrl: a behavioural grid_mem (read latency, one-cycle
// write register) plus a cell-array reference model updated per accepted request.
module tb_grid_deposit_ctrl;
    import grid_deposit_ctrl_pkg::*;

    localparam int     W     = CWIDTH;
    localparam int     RD    = GRID_RD_LAT;
    localparam int     NCELL = 1 << (2 * PINT);
    localparam longint MAXV  = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINV  = -(longint'(1) <<< (W - 1));

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    addr_t [3:0]          req_addr = '0;
    logic  [3:0][W-1:0]   req_inc = '0;
    logic  [3:0]          req_mask = '0;
    logic  [3:0]          mem_wea;
    addr_t [3:0]          mem_addra;
    logic  [3:0][W-1:0]   mem_dina;
    logic  [3:0]          mem_web;
    addr_t [3:0]          mem_addrb;
    logic  [3:0][W-1:0]   mem_dinb;
    logic                 mem_swap_rout;
    logic  [3:0][W-1:0]   mem_douta;
    logic                 idle;
    logic                 sat_flag;
    logic                 err_flag;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     web_seen = 0;
    longint ref_grid [NCELL];
    bit     exp_sat = 1'b0;
    bit     exp_err = 1'b0;

    // grid_mem model state
    bit    [W-1:0]      gmem [NCELL];
    bit    [3:0][W-1:0] rd_chain [RD];
    logic  [3:0]        wq_en = '0;
    addr_t [3:0]        wq_addr;
    logic  [3:0][W-1:0] wq_data;
    logic               load_en = 1'b0;
    int                 load_idx = 0;
    logic  [W-1:0]      load_data = '0;

    always #5 clk = ~clk;

    grid_deposit_ctrl #(
        .WIDTH  (W),
        .RD_LAT (RD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_inc       (req_inc),
        .req_mask      (req_mask),
        .mem_wea       (mem_wea),
        .mem_addra     (mem_addra),
        .mem_dina      (mem_dina),
        .mem_web       (mem_web),
        .mem_addrb     (mem_addrb),
        .mem_dinb      (mem_dinb),
        .mem_swap_rout (mem_swap_rout),
        .mem_douta     (mem_douta),
        .idle          (idle),
        .sat_flag      (sat_flag),
        .err_flag      (err_flag)
    );

    function automatic int cidx(input addr_t a);
        return int'({a.y, a.x});
    endfunction

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic addr_t mk(input int x, input int y);
        addr_t a;
        a.x = PINT'(x);
        a.y = PINT'(y);
        return a;
    endfunction

    // 2x2 neighbourhood with base (bx,by), zero increments
    function automatic deposit_req_t mkreq(input int bx, input int by, input logic [3:0] m);
        deposit_req_t r;
        r.addr[0] = mk(bx, by);
        r.addr[1] = mk(bx + 1, by);
        r.addr[2] = mk(bx, by + 1);
        r.addr[3] = mk(bx + 1, by + 1);
        r.inc     = '0;
        r.mask    = m;
        return r;
    endfunction

    // grid_mem: read sampled at the edge after addra, data RD cycles after
    // addra is presented; writes commit one edge after being sampled.
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            rd_chain[0][l] <= gmem[cidx(mem_addra[l])];
            if (wq_en[l]) begin
                gmem[cidx(wq_addr[l])] <= wq_data[l];
            end
        end
        for (int k = 1; k < RD; k++) begin
            rd_chain[k] <= rd_chain[k-1];
        end
        wq_en   <= mem_web;
        wq_addr <= mem_addrb;
        wq_data <= mem_dinb;
        if (load_en) begin
            gmem[load_idx] <= load_data;
        end
    end
    assign mem_douta = rd_chain[RD-1];

    always @(negedge clk) begin
        if (|mem_web) begin
            web_seen <= web_seen + 1;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: dropped on duplicate banks, else saturating add per masked lane
    task automatic ref_apply(input deposit_req_t r);
        bit dupl;
        longint s;
        dupl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (r.mask[i] && r.mask[j]
                    && (r.addr[i].y % 2 == r.addr[j].y % 2)
                    && (r.addr[i].x % 2 == r.addr[j].x % 2)) begin
                    dupl = 1'b1;
                end
            end
        end
        if (dupl) begin
            exp_err = 1'b1;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (r.mask[l]) begin
                    s = ref_grid[cidx(r.addr[l])] + sx(r.inc[l]);
                    if (s > MAXV) begin
                        s = MAXV;
                        exp_sat = 1'b1;
                    end else if (s < MINV) begin
                        s = MINV;
                        exp_sat = 1'b1;
                    end
                    ref_grid[cidx(r.addr[l])] = s;
                end
            end
        end
    endtask

    // Present a request at posedge+1 and hold until accepted; returns after accept edge +1
    task automatic send(input deposit_req_t r, input bit apply, output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        req_addr  = r.addr;
        req_inc   = r.inc;
        req_mask  = r.mask;
        req_valid = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            req_valid = 1'b0;
            check("accept_timeout", longint'(ok), 1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (ok && apply) begin
            ref_apply(r);
        end
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (idle) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("idle_timeout", longint'(idle), 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input addr_t a, input longint v);
        load_en   = 1'b1;
        load_idx  = cidx(a);
        load_data = W'(v);
        @(posedge clk);
        #1;
        load_en = 1'b0;
        ref_grid[cidx(a)] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        deposit_req_t r;
        int           st;
        int           tot;
        int           web0;
        longint       exp4 [4];
        int           bx;
        int           by;

        for (int i = 0; i < NCELL; i++) ref_grid[i] = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", longint'(req_ready), 0);
        check("rst_web", longint'(mem_web), 0);
        check("rst_idle", longint'(idle), 1);
        check("rst_sat", longint'(sat_flag), 0);
        check("rst_err", longint'(err_flag), 0);
        check("rst_addra", longint'(mem_addra), 0);
        check("rst_addrb", longint'(mem_addrb), 0);
        check("rst_dinb", longint'(|mem_dinb), 0);
        check("tie_wea", longint'(mem_wea), 0);
        check("tie_dina", longint'(|mem_dina), 0);
        check("tie_swap", longint'(mem_swap_rout), 1);
        rst = 1'b0;
        #1;
        check("ready_before_edge", longint'(req_ready), 0);
        @(posedge clk);
        #1;
        check("ready_after_rst", longint'(req_ready), 1);

        // Single deposit: write presented at T+5
        r = mkreq(2, 2, 4'hF);
        r.inc[0] = W'(5);
        r.inc[1] = W'(-3);
        r.inc[2] = W'(7);
        r.inc[3] = W'(1);
        exp4 = '{5, -3, 7, 1};
        send(r, 1'b1, st);
        repeat (4) @(posedge clk);
        #1;
        check("single_web_early", longint'(mem_web), 0);
        @(posedge clk);
        #1;
        check("single_web", longint'(mem_web), 15);
        for (int l = 0; l < 4; l++) begin
            check($sformatf("single_dinb%0d", l), sx(mem_dinb[l]), exp4[l]);
        end
        check("single_addrb3", longint'(mem_addrb[3]), longint'(mk(3, 3)));
        wait_idle();
        for (int l = 0; l < 4; l++) begin
            check($sformatf("single_cell%0d", l), sx(gmem[cidx(r.addr[l])]), exp4[l]);
        end

        // Same neighbourhood back-to-back: must stall and not lose an update
        r = mkreq(10, 10, 4'hF);
        for (int l = 0; l < 4; l++) r.inc[l] = W'(1);
        send(r, 1'b1, st);
        send(r, 1'b1, st);
        check("dbl_stalled", longint'(st > 0), 1);
        wait_idle();
        for (int l = 0; l < 4; l++) begin
            check($sformatf("dbl_cell%0d", l), sx(gmem[cidx(r.addr[l])]), 2);
        end

        // 64 disjoint requests at full rate
        tot = 0;
        for (int k = 0; k < 64; k++) begin
            r = mkreq(2 * (k % 8), 16 + 2 * (k / 8), 4'hF);
            for (int l = 0; l < 4; l++) r.inc[l] = W'($urandom_range(1, 1000));
            send(r, 1'b1, st);
            tot += st;
        end
        check("burst_stalls", tot, 0);
        repeat (6) @(posedge clk);
        #1;
        check("burst_idle_t6", longint'(idle), 0);
        @(posedge clk);
        #1;
        check("burst_idle_t7", longint'(idle), 1);
        for (int y = 16; y < 32; y++) begin
            for (int x = 0; x < 16; x++) begin
                check("burst_cell", sx(gmem[cidx(mk(x, y))]), ref_grid[cidx(mk(x, y))]);
            end
        end
        check("flag_sat_clean", longint'(sat_flag), longint'(exp_sat));
        check("flag_err_clean", longint'(err_flag), longint'(exp_err));

        // Saturation at both ends
        preload(mk(40, 40), MAXV);
        preload(mk(41, 40), MINV);
        r = mkreq(40, 40, 4'b0011);
        r.inc[0] = W'(10);
        r.inc[1] = W'(MINV);
        send(r, 1'b1, st);
        repeat (5) @(posedge clk);
        #1;
        check("sat_pos", sx(mem_dinb[0]), MAXV);
        check("sat_neg", sx(mem_dinb[1]), MINV);
        check("sat_flag", longint'(sat_flag), 1);
        wait_idle();

        // Partial mask
        r = mkreq(20, 40, 4'b0101);
        for (int l = 0; l < 4; l++) r.inc[l] = W'(3);
        send(r, 1'b1, st);
        repeat (5) @(posedge clk);
        #1;
        check("mask_web", longint'(mem_web), 5);
        wait_idle();
        check("mask_cell1", sx(gmem[cidx(r.addr[1])]), 0);
        check("mask_cell2", sx(gmem[cidx(r.addr[2])]), 3);

        // Duplicate bank selects: accepted, dropped, flagged
        web0 = web_seen;
        r.addr[0] = mk(0, 0);
        r.addr[1] = mk(2, 0);
        r.addr[2] = mk(1, 1);
        r.addr[3] = mk(3, 1);
        r.mask    = 4'b0011;
        for (int l = 0; l < 4; l++) r.inc[l] = W'(9);
        send(r, 1'b1, st);
        check("dup_ready", st, 0);
        check("dup_err", longint'(err_flag), 1);
        repeat (8) @(posedge clk);
        #1;
        check("dup_no_write", web_seen - web0, 0);
        check("dup_cell", sx(gmem[cidx(mk(0, 0))]), 0);

        // Randomised traffic in a small region to provoke hazards
        for (int k = 0; k < 300; k++) begin
            bx = $urandom_range(48, 54);
            by = $urandom_range(48, 54);
            r  = mkreq(bx, by, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 9) == 0) r.addr[1] = mk(bx + 2, by);
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 7) == 0) begin
                    r.inc[l] = $urandom_range(0, 1) ? W'(MAXV - 15) : W'(MINV + 15);
                end else begin
                    r.inc[l] = W'(int'($urandom_range(0, 200)) - 100);
                end
            end
            send(r, 1'b1, st);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        check("rand_sat", longint'(sat_flag), longint'(exp_sat));
        check("rand_err", longint'(err_flag), longint'(exp_err));

        // Reset two cycles after an accept abandons the write
        web0 = web_seen;
        r = mkreq(8, 56, 4'hF);
        for (int l = 0; l < 4; l++) r.inc[l] = W'(4);
        send(r, 1'b0, st);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ready", longint'(req_ready), 0);
        check("mid_rst_web", longint'(mem_web), 0);
        check("mid_rst_idle", longint'(idle), 1);
        check("mid_rst_sat", longint'(sat_flag), 0);
        check("mid_rst_err", longint'(err_flag), 0);
        check("mid_rst_addra", longint'(mem_addra), 0);
        check("mid_rst_addrb", longint'(mem_addrb), 0);
        check("mid_rst_dinb", longint'(|mem_dinb), 0);
        rst = 1'b0;
        exp_sat = 1'b0;
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_ready_rel", longint'(req_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        check("mid_rst_no_web", web_seen - web0, 0);

        // Whole grid against the reference
        for (int i = 0; i < NCELL; i++) begin
            check($sformatf("grid%0d", i), sx(gmem[i]), ref_grid[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
